// File: rtl/mealy_stream_sched.sv
// Round-robin front end that time-shares one serial Mealy FSM between two requesters.
// Job latency: done pulses LEN+2 cycles after acceptance; no backpressure, req is held until ack.
module mealy_stream_sched #(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    input  logic [LEN-1:0] pat0,
    input  logic [LEN-1:0] pat1,
    output logic [1:0]     ack,
    output logic           busy,
    output logic           done,
    output logic           done_id,
    output logic [LEN-1:0] result,
    output logic [2:0]     final_state,
    output logic           fsm_rst_n,
    output logic           fsm_in,
    input  logic           fsm_out,
    input  logic [2:0]     fsm_state
);

    localparam int CW = $clog2(LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic           last_grant;
    logic           cur_id;
    logic           grant;
    logic           accept;
    logic           last_bit;
    logic [LEN-1:0] pat_q;
    logic [LEN-2:0] shreg;
    logic [LEN-1:0] shreg_nx;

    assign last_bit = (cnt == CW'(LEN - 1));
    assign shreg_nx = {shreg, fsm_out};

    // Under contention the requester that was not served last time wins.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    accept   = 1'b1;
                    state_nx = CLR;
                end
            end
            CLR:  state_nx = RUN;
            RUN:  if (last_bit) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            ack         <= 2'b00;
            done_id     <= 1'b0;
            result      <= '0;
            final_state <= 3'd0;
            pat_q       <= '0;
            shreg       <= '0;
        end else begin
            state <= state_nx;
            ack   <= accept ? (2'b01 << grant) : 2'b00;
            if (accept) begin
                pat_q      <= grant ? pat1 : pat0;
                last_grant <= grant;
                cur_id     <= grant;
                cnt        <= '0;
            end
            if (state == RUN) begin
                shreg <= shreg_nx[LEN-2:0];
                pat_q <= pat_q << 1;
                cnt   <= cnt + CW'(1);
                // Published only on the last bit so result stays stable between jobs.
                if (last_bit) begin
                    result      <= shreg_nx;
                    final_state <= fsm_state;
                    done_id     <= cur_id;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_rst_n = (state == RUN);
    assign fsm_in    = (state == RUN) & pat_q[LEN-1];

endmodule

// File: tb/tb_mealy_stream_sched.sv
// Directed plus randomized bench for mealy_stream_sched, with a small lab Mealy FSM attached.
module tb_mealy_stream_sched;

    localparam int LEN = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req = 2'b00;
    logic [LEN-1:0] pat0 = '0;
    logic [LEN-1:0] pat1 = '0;
    logic [1:0]     ack;
    logic           busy;
    logic           done;
    logic           done_id;
    logic [LEN-1:0] result;
    logic [2:0]     final_state;
    logic           fsm_rst_n;
    logic           fsm_in;
    logic           fsm_out;
    logic [2:0]     fsm_state;

    mealy_stream_sched #(.LEN(LEN)) dut (
        .clk(clk), .rst(rst), .req(req), .pat0(pat0), .pat1(pat1),
        .ack(ack), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .final_state(final_state),
        .fsm_rst_n(fsm_rst_n), .fsm_in(fsm_in),
        .fsm_out(fsm_out), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_done = 0;
    logic lg = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Lab sequence FSM: returns {out, next_state}.
    function automatic logic [3:0] fsm_step(input logic [2:0] s, input logic i);
        case ({s, i})
            {3'd0, 1'b1}: return {1'b1, 3'd1};
            {3'd1, 1'b0}: return {1'b1, 3'd5};
            {3'd1, 1'b1}: return {1'b0, 3'd2};
            {3'd2, 1'b0}: return {1'b1, 3'd2};
            {3'd2, 1'b1}: return {1'b1, 3'd3};
            {3'd3, 1'b0}: return {1'b1, 3'd6};
            {3'd3, 1'b1}: return {1'b1, 3'd4};
            {3'd4, 1'b1}: return {1'b1, 3'd4};
            {3'd5, 1'b1}: return {1'b0, 3'd2};
            {3'd6, 1'b0}: return {1'b1, 3'd5};
            default:      return {1'b0, 3'd0};
        endcase
    endfunction

    logic [2:0] fsm_q;
    logic [3:0] fsm_nx;
    assign fsm_nx    = fsm_step(fsm_q, fsm_in);
    assign fsm_out   = fsm_nx[3];
    assign fsm_state = fsm_q;

    always @(posedge clk) begin
        if (!fsm_rst_n) fsm_q <= 3'd0;
        else            fsm_q <= fsm_nx[2:0];
    end

    // Expected {final_state, result}: final_state is the state seen while the last bit is applied.
    function automatic logic [LEN+2:0] ref_job(input logic [LEN-1:0] p);
        logic [2:0]     s;
        logic [2:0]     fin;
        logic [LEN-1:0] r;
        logic [3:0]     st;
        s = 3'd0; fin = 3'd0; r = '0;
        for (int i = 0; i < LEN; i++) begin
            if (i == LEN - 1) fin = s;
            st = fsm_step(s, p[LEN-1-i]);
            r  = {r[LEN-2:0], st[3]};
            s  = st[2:0];
        end
        return {fin, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic job(input logic [1:0] r, input logic [LEN-1:0] p0, input logic [LEN-1:0] p1,
                       input bit hold, input bit chg, input bit space);
        int n, hi, busy_lo, ack_extra, early_done;
        logic g;
        logic [LEN+2:0] e;
        bit got;
        req = r; pat0 = p0; pat1 = p1;
        got = 0; early_done = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack != 2'b00) got = 1;
            else early_done += int'(done);
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("done_pulse_width", early_done, 0);
        g  = (r == 2'b11) ? ~lg : r[1];
        e  = ref_job(g ? p1 : p0);
        lg = g;
        chk("ack_onehot", 32'(ack), 32'(2'b01 << g));
        chk("clr_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
        chk("busy_clr", 32'(busy), 32'd1);
        if (!hold) req = 2'b00;
        if (chg) pat0 = '0;
        n = 1; hi = 0; busy_lo = 0; ack_extra = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
            else begin
                hi        += int'(fsm_rst_n);
                busy_lo   += int'(!busy);
                ack_extra += int'(ack != 2'b00);
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("done_latency", n, LEN + 2);
        chk("result", 32'(result), 32'(e[LEN-1:0]));
        chk("final_state", 32'(final_state), 32'(e[LEN+2:LEN]));
        chk("done_id", 32'(done_id), 32'(g));
        chk("run_cycles", hi, LEN);
        chk("busy_job", busy_lo, 0);
        chk("ack_one_cycle", ack_extra, 0);
        chk("busy_done", 32'(busy), 32'd1);
        if (space) chk("done_spacing", cyc - last_done, LEN + 3);
        last_done = cyc;
    endtask

    initial begin
        int donec;
        bit got;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_final", 32'(final_state), 32'd0);
        chk("rst_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
        chk("rst_fsm_in", 32'(fsm_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        job(2'b01, 8'hB2, 8'h00, 0, 0, 0);
        chk("plan_b2", 32'(result), 32'hDD);
        job(2'b10, 8'h00, 8'hFF, 0, 0, 0);
        chk("plan_ff", 32'(result), 32'hBF);
        chk("plan_ff_state", 32'(final_state), 32'd4);

        for (int k = 0; k < 4; k++) begin
            job(2'b11, 8'hB2, 8'hFF, 1, 0, k > 0);
            chk("alt_grant", 32'(done_id), 32'(k % 2));
        end
        req = 2'b00;

        job(2'b01, 8'h00, 8'h5A, 0, 0, 0);
        chk("plan_zero", 32'(result), 32'h00);
        job(2'b01, 8'hB2, 8'h00, 0, 1, 0);
        chk("latched_pat", 32'(result), 32'hDD);

        // Abort a job in its 4th RUN cycle.
        req = 2'b01; pat0 = 8'hB2;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack != 2'b00) got = 1;
        end
        chk("abort_ack", 32'(ack), 32'd1);
        req = 2'b00;
        repeat (4) @(negedge clk);
        chk("abort_in_run", 32'(fsm_rst_n), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        donec = 0;
        req = 2'b11; pat0 = 8'hB2; pat1 = 8'hFF;
        for (int k = 0; k < LEN + 4; k++) begin
            @(negedge clk);
            donec += int'(done) + int'(ack != 2'b00);
            if (k == 1) rst = 1'b0;
            if (k == 0) req = 2'b00;
        end
        chk("abort_no_done", donec, 0);
        lg = 1'b1;
        job(2'b11, 8'hB2, 8'hFF, 0, 0, 0);
        chk("abort_first_grant", 32'(done_id), 32'd0);

        for (int k = 0; k < 20; k++) begin
            job(2'($urandom_range(1, 3)), LEN'($urandom), LEN'($urandom), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
